// File: rtl/spi_slave_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_tx
// Purpose  : SPI mode-0 slave transmitter, MSB first. Returns data from the
//            fabric to the SPI master on MISO. SCK and CS are oversampled in
//            the i_clk domain; no logic is clocked by SCK.
// Ports    : i_clk       system clock (>= 8x SCK)
//            i_rst       synchronous active-low reset
//            i_sck       SPI clock from master (idles low)
//            i_cs        chip select, active-low
//            o_miso      serial data to master
//            o_miso_en   MISO output enable (pin tri-stated when 0)
//            i_tx_data   word to transmit
//            i_tx_valid  i_tx_data is valid
//            o_tx_ready  holding register empty; word accepted on valid&ready
//            o_byte_done one-cycle pulse after the last bit of a word
//            o_underrun  one-cycle pulse when FILL_BYTE is loaded
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_tx #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] FILL_BYTE   = 8'hFF,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sck,
    input  logic              i_cs,
    output logic              o_miso,
    output logic              o_miso_en,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_byte_done,
    output logic              o_underrun
);

    localparam int              c_CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_sync_q, w_sck_sync_d;
    logic [SYNC_STAGES-1:0] r_cs_sync_q,  w_cs_sync_d;
    logic                   r_sck_prev_q;
    logic                   r_cs_prev_q;
    // Fills with ones after reset; the CS chain only holds real samples
    // once the top bit is set.
    logic [SYNC_STAGES:0]   r_warm_q,     w_warm_d;

    state_t                 r_state_q,     w_state_d;
    logic [DATA_W-1:0]      r_shift_q,     w_shift_d;
    logic [c_CNT_W-1:0]     r_cnt_q,       w_cnt_d;
    logic [DATA_W-1:0]      r_hold_q,      w_hold_d;
    logic                   r_hold_full_q, w_hold_full_d;
    logic                   r_miso_q,      w_miso_d;
    logic                   r_miso_en_q,   w_miso_en_d;
    logic                   r_byte_done_q, w_byte_done_d;
    logic                   r_underrun_q,  w_underrun_d;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_sck_s;
    logic w_cs_s;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_warm_done;

    always_comb begin
        w_sck_sync_d    = r_sck_sync_q;
        w_cs_sync_d     = r_cs_sync_q;
        w_warm_d        = r_warm_q;
        w_sck_sync_d[0] = i_sck;
        w_cs_sync_d[0]  = i_cs;
        w_warm_d[0]     = 1'b1;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            w_sck_sync_d[k] = r_sck_sync_q[k-1];
            w_cs_sync_d[k]  = r_cs_sync_q[k-1];
        end
        for (int k = 1; k <= SYNC_STAGES; k++) begin
            w_warm_d[k] = r_warm_q[k-1];
        end
    end

    assign w_sck_s     = r_sck_sync_q[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync_q[SYNC_STAGES-1];
    assign w_warm_done = r_warm_q[SYNC_STAGES];
    assign w_sck_rise  = w_sck_s & ~r_sck_prev_q;
    assign w_sck_fall  = ~w_sck_s & r_sck_prev_q;
    assign w_cs_rise   = w_cs_s & ~r_cs_prev_q;
    // The CS chain is preset high in reset. If CS is already low when reset
    // releases, the preset ones drain out and would look like a falling
    // edge; gating with the warm-up flag ignores that artefact so the master
    // has to deselect and reselect before anything is sent.
    assign w_cs_fall   = ~w_cs_s & r_cs_prev_q & w_warm_done;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    logic w_load;

    always_comb begin
        w_state_d     = r_state_q;
        w_shift_d     = r_shift_q;
        w_cnt_d       = r_cnt_q;
        w_hold_d      = r_hold_q;
        w_hold_full_d = r_hold_full_q;
        w_byte_done_d = 1'b0;
        w_underrun_d  = 1'b0;
        w_load        = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_d = ST_SHIFT;
                    w_cnt_d   = '0;
                    w_load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Deselect wins over any SCK edge seen in the same cycle;
                // a partially sent word is simply dropped.
                if (w_cs_rise) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (w_sck_rise) begin
                    if (r_cnt_q == c_LAST_BIT) begin
                        w_cnt_d       = '0;
                        w_byte_done_d = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end else if (w_sck_fall) begin
                    // Count back at zero on a falling edge means the master
                    // has just taken the last bit: present the next word.
                    if (r_cnt_q == '0) begin
                        w_load = 1'b1;
                    end else begin
                        w_shift_d = r_shift_q << 1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_load) begin
            if (r_hold_full_q) begin
                w_shift_d     = r_hold_q;
                w_hold_full_d = 1'b0;
            end else begin
                w_shift_d    = FILL_BYTE;
                w_underrun_d = 1'b1;
            end
        end

        // Ready is the registered inverse of hold_full, so a slot freed by
        // a load this cycle is only offered from the next cycle on.
        if (i_tx_valid && !r_hold_full_q) begin
            w_hold_d      = i_tx_data;
            w_hold_full_d = 1'b1;
        end

        w_miso_en_d = (w_state_d == ST_SHIFT);
        w_miso_d    = (w_state_d == ST_SHIFT) ? w_shift_d[DATA_W-1] : 1'b0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sck_sync_q  <= '0;
            r_cs_sync_q   <= '1;
            r_sck_prev_q  <= 1'b0;
            r_cs_prev_q   <= 1'b1;
            r_warm_q      <= '0;
            r_state_q     <= ST_IDLE;
            r_shift_q     <= '0;
            r_cnt_q       <= '0;
            r_hold_q      <= '0;
            r_hold_full_q <= 1'b0;
            r_miso_q      <= 1'b0;
            r_miso_en_q   <= 1'b0;
            r_byte_done_q <= 1'b0;
            r_underrun_q  <= 1'b0;
        end else begin
            r_sck_sync_q  <= w_sck_sync_d;
            r_cs_sync_q   <= w_cs_sync_d;
            r_sck_prev_q  <= w_sck_s;
            r_cs_prev_q   <= w_cs_s;
            r_warm_q      <= w_warm_d;
            r_state_q     <= w_state_d;
            r_shift_q     <= w_shift_d;
            r_cnt_q       <= w_cnt_d;
            r_hold_q      <= w_hold_d;
            r_hold_full_q <= w_hold_full_d;
            r_miso_q      <= w_miso_d;
            r_miso_en_q   <= w_miso_en_d;
            r_byte_done_q <= w_byte_done_d;
            r_underrun_q  <= w_underrun_d;
        end
    end

    assign o_miso      = r_miso_q;
    assign o_miso_en   = r_miso_en_q;
    assign o_tx_ready  = ~r_hold_full_q;
    assign o_byte_done = r_byte_done_q;
    assign o_underrun  = r_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_tx
// Purpose  : Self-checking bench for spi_slave_tx. A table of single-word
//            transfers plus hand-written sequences for back-to-back words,
//            aborted words, dropped writes and reset mid-transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_tx;

    logic       clk;
    logic       rst;
    logic       sck;
    logic       cs;
    logic       miso;
    logic       miso_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       byte_done;
    logic       underrun;

    int n_checks;
    int n_errors;
    int n_done;
    int n_under;

    spi_slave_tx #(
        .DATA_W      (8),
        .FILL_BYTE   (8'hFF),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sck       (sck),
        .i_cs        (cs),
        .o_miso      (miso),
        .o_miso_en   (miso_en),
        .i_tx_data   (tx_data),
        .i_tx_valid  (tx_valid),
        .o_tx_ready  (tx_ready),
        .o_byte_done (byte_done),
        .o_underrun  (underrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    initial begin
        n_done  = 0;
        n_under = 0;
    end
    always @(negedge clk) begin
        if (byte_done) n_done  <= n_done + 1;
        if (underrun)  n_under <= n_under + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clks(1);
        tx_valid = 1'b0;
        wait_clks(1);
    endtask

    // One SCK pulse: 12 clk low, 12 clk high. Master samples MISO on the rise.
    task automatic sck_pulse(output logic bit_out);
        wait_clks(12);
        sck     = 1'b1;
        bit_out = miso;
        wait_clks(12);
        sck     = 1'b0;
    endtask

    // Full CS window. d_under is taken shortly after the last rise, before
    // the final fall presents the following word.
    task automatic run_window(input int nbits, input logic mid_wr, input logic [7:0] mid_data,
                              output logic [15:0] rx, output int d_done, output int d_under,
                              output logic en_seen);
        int done0;
        int under0;
        done0   = n_done;
        under0  = n_under;
        rx      = '0;
        en_seen = 1'b0;
        d_under = 0;
        cs      = 1'b0;
        wait_clks(12);
        if (mid_wr) begin
            chk("ready_after_first_load", {31'd0, tx_ready}, 32'd1);
            write_word(mid_data);
        end
        for (int b = 0; b < nbits; b++) begin
            wait_clks(12);
            sck = 1'b1;
            rx  = {rx[14:0], miso};
            if (b == 0) en_seen = miso_en;
            wait_clks(10);
            if (b == nbits - 1) d_under = n_under - under0;
            wait_clks(2);
            sck = 1'b0;
        end
        wait_clks(12);
        cs = 1'b1;
        wait_clks(8);
        d_done = n_done - done0;
    endtask

    typedef struct {
        logic       do_wr;
        logic [7:0] wr;
        logic [7:0] exp_rx;
        int         exp_done;
        int         exp_under;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] rx;
    int          d_done;
    int          d_under;
    logic        en_seen;
    logic        bit_s;
    int          done0;

    initial begin
        vecs[0] = '{do_wr: 1'b1, wr: 8'hA5, exp_rx: 8'hA5, exp_done: 1, exp_under: 0};
        vecs[1] = '{do_wr: 1'b0, wr: 8'h00, exp_rx: 8'hFF, exp_done: 1, exp_under: 1};
        vecs[2] = '{do_wr: 1'b1, wr: 8'h81, exp_rx: 8'h81, exp_done: 1, exp_under: 0};
        vecs[3] = '{do_wr: 1'b1, wr: 8'h00, exp_rx: 8'h00, exp_done: 1, exp_under: 0};

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        cs       = 1'b1;
        sck      = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;

        // Reset state
        wait_clks(3);
        chk("reset_miso",      {31'd0, miso},      32'd0);
        chk("reset_miso_en",   {31'd0, miso_en},   32'd0);
        chk("reset_tx_ready",  {31'd0, tx_ready},  32'd1);
        chk("reset_byte_done", {31'd0, byte_done}, 32'd0);
        chk("reset_underrun",  {31'd0, underrun},  32'd0);
        rst = 1'b1;
        wait_clks(10);

        // Table of single-word transfers
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].do_wr) begin
                write_word(vecs[i].wr);
                chk("ready_after_write", {31'd0, tx_ready}, 32'd0);
            end else begin
                chk("ready_when_empty", {31'd0, tx_ready}, 32'd1);
            end
            run_window(8, 1'b0, 8'h00, rx, d_done, d_under, en_seen);
            chk("vec_rx",        {24'd0, rx[7:0]}, {24'd0, vecs[i].exp_rx});
            chk("vec_byte_done", d_done,           vecs[i].exp_done);
            chk("vec_underrun",  d_under,          vecs[i].exp_under);
            chk("vec_miso_en",   {31'd0, en_seen}, 32'd1);
            chk("vec_ready_end", {31'd0, tx_ready}, 32'd1);
            chk("vec_en_idle",   {31'd0, miso_en}, 32'd0);
        end

        // Back-to-back words in one CS window
        write_word(8'h3C);
        run_window(16, 1'b1, 8'hC3, rx, d_done, d_under, en_seen);
        chk("b2b_rx",        {16'd0, rx}, 32'h3CC3);
        chk("b2b_byte_done", d_done,      2);
        chk("b2b_underrun",  d_under,     0);

        // Word aborted by CS rising after 4 bits
        write_word(8'hF0);
        run_window(4, 1'b0, 8'h00, rx, d_done, d_under, en_seen);
        chk("abort_rx_nibble", {16'd0, rx}, 32'h000F);
        chk("abort_byte_done", d_done,      0);
        chk("abort_miso_en",   {31'd0, miso_en}, 32'd0);
        run_window(8, 1'b0, 8'h00, rx, d_done, d_under, en_seen);
        chk("post_abort_rx",        {24'd0, rx[7:0]}, 32'hFF);
        chk("post_abort_underrun",  d_under,          1);
        chk("post_abort_byte_done", d_done,           1);

        // Write while full is dropped
        write_word(8'h11);
        tx_data  = 8'h22;
        tx_valid = 1'b1;
        wait_clks(3);
        chk("full_ready_low", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        wait_clks(2);
        run_window(8, 1'b0, 8'h00, rx, d_done, d_under, en_seen);
        chk("drop_rx",       {24'd0, rx[7:0]}, 32'h11);
        chk("drop_underrun", d_under,          0);

        // Reset mid-word with CS held low
        write_word(8'h77);
        cs = 1'b0;
        for (int b = 0; b < 3; b++) sck_pulse(bit_s);
        rst = 1'b0;
        wait_clks(2);
        rst = 1'b1;
        wait_clks(1);
        chk("rst_mid_miso_en",  {31'd0, miso_en},  32'd0);
        chk("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_mid_miso",     {31'd0, miso},     32'd0);
        done0 = n_done;
        for (int b = 0; b < 8; b++) sck_pulse(bit_s);
        wait_clks(12);
        chk("rst_mid_no_done", n_done - done0,   0);
        chk("rst_mid_en_low",  {31'd0, miso_en}, 32'd0);
        cs = 1'b1;
        wait_clks(8);
        run_window(8, 1'b0, 8'h00, rx, d_done, d_under, en_seen);
        chk("rst_after_rx",        {24'd0, rx[7:0]}, 32'hFF);
        chk("rst_after_byte_done", d_done,           1);
        chk("rst_after_underrun",  d_under,          1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
